// File: rtl/el2_ifu_axi_rd_resp.sv
// AXI4 read-response slave for the IFU fetch port: serves one burst at a time from a 64-bit backing store.
// Optional feature: define EL2_IFU_AXI_RD_RESP_ARQ_EN to put a 2-entry AR queue in front of the burst FSM.
module el2_ifu_axi_rd_resp #(
  parameter logic [31:0] MEM_BASE = 32'h0000_0000,
  parameter int          MEM_AW   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_ifu_axi_arvalid,
  output logic              io_ifu_axi_arready,
  input  logic [2:0]        io_ifu_axi_arid,
  input  logic [31:0]       io_ifu_axi_araddr,
  input  logic [7:0]        io_ifu_axi_arlen,
  input  logic [2:0]        io_ifu_axi_arsize,
  input  logic [1:0]        io_ifu_axi_arburst,
  output logic              io_ifu_axi_rvalid,
  input  logic              io_ifu_axi_rready,
  output logic [2:0]        io_ifu_axi_rid,
  output logic [63:0]       io_ifu_axi_rdata,
  output logic [1:0]        io_ifu_axi_rresp,
  output logic              io_ifu_axi_rlast,
  output logic              io_mem_rd_en,
  output logic [MEM_AW-4:0] io_mem_addr,
  input  logic [63:0]       io_mem_rd_data,
  output logic [1:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never waits on ready, and valid plus payload hold steady until the transfer.
  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, RSP = 2'd2} state_t;

  state_t      state;
  logic        rst_done;
  logic [2:0]  id_q;
  logic [31:0] addr_q;
  logic [7:0]  len_q, cnt_q;
  logic [1:0]  burst_q;
  logic        legal_q, beat_ok_q;

  logic        req_valid, req_take;
  logic [2:0]  req_id, req_size;
  logic [31:0] req_addr, start_addr, inc_addr, wrap_mask, nxt_addr;
  logic [7:0]  req_len;
  logic [1:0]  req_burst;
  logic        start_ok, nxt_ok;

  function automatic logic in_window(input logic [31:0] a);
    logic [31:0] off;
    off = a - MEM_BASE;
    return (off >> MEM_AW) == 32'd0;
  endfunction

  function automatic logic burst_legal(input logic [2:0] size, input logic [1:0] burst,
                                       input logic [7:0] len);
    logic wrap_len;
    wrap_len = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (size == 3'd3) &&
           ((burst == 2'b00) || (burst == 2'b01) || ((burst == 2'b10) && wrap_len));
  endfunction

`ifdef EL2_IFU_AXI_RD_RESP_ARQ_EN
  logic [47:0] fifo_mem [2];
  logic        wr_ptr, rd_ptr, fifo_push;
  logic [1:0]  fifo_cnt;

  // A full queue still accepts when IDLE drains the head in the same cycle.
  assign io_ifu_axi_arready = rst_done && ((fifo_cnt != 2'd2) || req_take);
  assign fifo_push = io_ifu_axi_arvalid && io_ifu_axi_arready;
  assign req_valid = (fifo_cnt != 2'd0);
  assign {req_id, req_addr, req_len, req_size, req_burst} = fifo_mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (fifo_push)
      fifo_mem[wr_ptr] <= {io_ifu_axi_arid, io_ifu_axi_araddr, io_ifu_axi_arlen,
                           io_ifu_axi_arsize, io_ifu_axi_arburst};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (fifo_push) wr_ptr <= !wr_ptr;
      if (req_take)  rd_ptr <= !rd_ptr;
      case ({fifo_push, req_take})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end
`else
  assign io_ifu_axi_arready = rst_done && (state == IDLE);
  assign req_valid = io_ifu_axi_arvalid && io_ifu_axi_arready;
  assign req_id    = io_ifu_axi_arid;
  assign req_addr  = io_ifu_axi_araddr;
  assign req_len   = io_ifu_axi_arlen;
  assign req_size  = io_ifu_axi_arsize;
  assign req_burst = io_ifu_axi_arburst;
`endif

  assign req_take   = (state == IDLE) && req_valid;
  assign start_addr = req_addr & ~32'h7;
  assign start_ok   = burst_legal(req_size, req_burst, req_len) && in_window(start_addr);

  // WRAP boundary is (len+1)*8 bytes, so the in-boundary mask is simply {len, 3'b111}.
  assign inc_addr  = addr_q + 32'd8;
  assign wrap_mask = {21'd0, len_q, 3'b111};

  always_comb begin
    nxt_addr = inc_addr;
    case (burst_q)
      2'b00:   nxt_addr = addr_q;
      2'b10:   nxt_addr = (addr_q & ~wrap_mask) | (inc_addr & wrap_mask);
      default: nxt_addr = inc_addr;
    endcase
  end

  assign nxt_ok = legal_q && in_window(nxt_addr);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      rst_done          <= 1'b0;
      id_q              <= 3'd0;
      addr_q            <= 32'd0;
      len_q             <= 8'd0;
      cnt_q             <= 8'd0;
      burst_q           <= 2'b00;
      legal_q           <= 1'b0;
      beat_ok_q         <= 1'b0;
      io_ifu_axi_rvalid <= 1'b0;
      io_ifu_axi_rid    <= 3'd0;
      io_ifu_axi_rresp  <= 2'b00;
      io_ifu_axi_rlast  <= 1'b0;
      io_mem_rd_en      <= 1'b0;
      io_mem_addr       <= '0;
    end else begin
      rst_done     <= 1'b1;
      io_mem_rd_en <= 1'b0;
      case (state)
        IDLE: begin
          if (req_take) begin
            id_q         <= req_id;
            addr_q       <= start_addr;
            len_q        <= req_len;
            burst_q      <= req_burst;
            legal_q      <= burst_legal(req_size, req_burst, req_len);
            cnt_q        <= 8'd0;
            beat_ok_q    <= start_ok;
            io_mem_rd_en <= start_ok;
            io_mem_addr  <= start_addr[MEM_AW-1:3];
            state        <= RD;
          end
        end
        RD: begin
          io_ifu_axi_rvalid <= 1'b1;
          io_ifu_axi_rid    <= id_q;
          io_ifu_axi_rresp  <= beat_ok_q ? 2'b00 : 2'b10;
          io_ifu_axi_rlast  <= (cnt_q == len_q);
          state             <= RSP;
        end
        RSP: begin
          if (io_ifu_axi_rready) begin
            io_ifu_axi_rvalid <= 1'b0;
            io_ifu_axi_rlast  <= 1'b0;
            if (io_ifu_axi_rlast) begin
              state <= IDLE;
            end else begin
              addr_q       <= nxt_addr;
              cnt_q        <= cnt_q + 8'd1;
              beat_ok_q    <= nxt_ok;
              io_mem_rd_en <= nxt_ok;
              io_mem_addr  <= nxt_addr[MEM_AW-1:3];
              state        <= RD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Store data is held until the next read strobe, so passing it through keeps rdata stable under backpressure.
  assign io_ifu_axi_rdata = (io_ifu_axi_rvalid && (io_ifu_axi_rresp == 2'b00)) ? io_mem_rd_data : 64'd0;
  assign dbg_state = state;

endmodule

// File: tb/tb_el2_ifu_axi_rd_resp.sv
// Directed bench for el2_ifu_axi_rd_resp: memory model, R-channel scoreboard and hand-computed beats.
module tb_el2_ifu_axi_rd_resp;

  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam int          AW   = 16;
`ifdef EL2_IFU_AXI_RD_RESP_ARQ_EN
  localparam int   LAT        = 3;
  localparam logic BUSY_READY = 1'b1;
`else
  localparam int   LAT        = 2;
  localparam logic BUSY_READY = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          arvalid = 1'b0, arready;
  logic [2:0]    arid = 3'd0, arsize = 3'd0;
  logic [31:0]   araddr = 32'd0;
  logic [7:0]    arlen = 8'd0;
  logic [1:0]    arburst = 2'b00;
  logic          rvalid, rready = 1'b1, rlast;
  logic [2:0]    rid;
  logic [63:0]   rdata;
  logic [1:0]    rresp;
  logic          mem_rd_en;
  logic [AW-4:0] mem_addr;
  logic [63:0]   mem_rd_data = 64'd0;
  logic [1:0]    dbg_state;
  logic [71:0]   obs;

  logic [71:0] exp_q[$];
  int          rv_rise_q[$];
  int          beat_cyc[$];
  int          cyc = 0, rd_cnt = 0, beats_seen = 0;
  int          n_checks = 0, n_fail = 0;
  logic        rv_prev = 1'b0;

  el2_ifu_axi_rd_resp #(.MEM_BASE(BASE), .MEM_AW(AW)) dut (
    .clock(clock), .reset(reset),
    .io_ifu_axi_arvalid(arvalid), .io_ifu_axi_arready(arready), .io_ifu_axi_arid(arid),
    .io_ifu_axi_araddr(araddr), .io_ifu_axi_arlen(arlen), .io_ifu_axi_arsize(arsize),
    .io_ifu_axi_arburst(arburst), .io_ifu_axi_rvalid(rvalid), .io_ifu_axi_rready(rready),
    .io_ifu_axi_rid(rid), .io_ifu_axi_rdata(rdata), .io_ifu_axi_rresp(rresp),
    .io_ifu_axi_rlast(rlast), .io_mem_rd_en(mem_rd_en), .io_mem_addr(mem_addr),
    .io_mem_rd_data(mem_rd_data), .dbg_state(dbg_state)
  );

  assign obs = {1'b0, rvalid, rid, rresp, rlast, rdata};

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- memory model ----------------
  function automatic logic [63:0] mem_word(input logic [AW-4:0] idx);
    return {32'hC0DE_0000 | {19'd0, idx}, ~{19'd0, idx}};
  endfunction

  always @(posedge clock) begin
    if (mem_rd_en) begin
      mem_rd_data <= mem_word(mem_addr);
      rd_cnt      <= rd_cnt + 1;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] beat_ok(input logic [2:0] id, input int idx, input logic last);
    logic [AW-4:0] w;
    w = idx[AW-4:0];
    return {1'b0, 1'b1, id, 2'b00, last, mem_word(w)};
  endfunction

  function automatic logic [71:0] beat_err(input logic [2:0] id, input logic last);
    return {1'b0, 1'b1, id, 2'b10, last, 64'd0};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clock) begin
    if (reset) begin
      if (rvalid && !rv_prev) rv_rise_q.push_back(cyc);
      if (rvalid && rready) begin
        beats_seen++;
        beat_cyc.push_back(cyc);
        if (exp_q.size() == 0) check("unexpected_beat", obs, 72'd0);
        else check("r_beat", obs, exp_q.pop_front());
      end
    end
    rv_prev = rvalid;
  end

  // ---------------- driver tasks ----------------
  task automatic send_ar(input logic [2:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, output int acc);
    int n;
    n = 0;
    arvalid = 1'b1; arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
    @(negedge clock);
    while (!arready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!arready) check("ar_timeout", 72'(arready), 72'd1);
    acc = cyc;
    @(posedge clock); #1;
    arvalid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      check(tag, 72'(exp_q.size()), 72'd0);
      exp_q.delete();
    end
    repeat (4) @(posedge clock);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t, n, n0, b0, r0;
    #2 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_r_outputs", obs, 72'd0);
    check("reset_ctrl", 72'({arready, mem_rd_en, mem_addr}), 72'd0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("arready_before_edge", 72'(arready), 72'd0);
    @(posedge clock); #1;
    check("arready_after_release", 72'(arready), 72'd1);

    // INCR, 4 beats from word 2
    n0 = rv_rise_q.size(); b0 = beat_cyc.size(); r0 = rd_cnt;
    for (int k = 0; k < 4; k++) exp_q.push_back(beat_ok(3'd5, 2 + k, k == 3));
    send_ar(3'd5, BASE + 32'h10, 8'd3, 3'd3, 2'b01, t);
    check("arready_busy", 72'(arready), 72'(BUSY_READY));
    wait_done("incr_timeout");
    check("incr_latency", 72'(rv_rise_q.size() > n0 ? rv_rise_q[n0] - t : -1), 72'(LAT));
    check("incr_gap_01", 72'(beat_cyc.size() > b0 + 3 ? beat_cyc[b0+1] - beat_cyc[b0] : -1), 72'd2);
    check("incr_gap_23", 72'(beat_cyc.size() > b0 + 3 ? beat_cyc[b0+3] - beat_cyc[b0+2] : -1), 72'd2);
    check("incr_rd_count", 72'(rd_cnt - r0), 72'd4);

    // WRAP from word 3 of a 32-byte block; FIXED with unaligned start
    r0 = rd_cnt;
    exp_q.push_back(beat_ok(3'd1, 3, 1'b0));
    exp_q.push_back(beat_ok(3'd1, 0, 1'b0));
    exp_q.push_back(beat_ok(3'd1, 1, 1'b0));
    exp_q.push_back(beat_ok(3'd1, 2, 1'b1));
    send_ar(3'd1, BASE + 32'h18, 8'd3, 3'd3, 2'b10, t);
    wait_done("wrap_timeout");
    for (int k = 0; k < 3; k++) exp_q.push_back(beat_ok(3'd2, 5, k == 2));
    send_ar(3'd2, BASE + 32'h2F, 8'd2, 3'd3, 2'b00, t);
    wait_done("fixed_timeout");
    check("wrap_fixed_rd_count", 72'(rd_cnt - r0), 72'd7);

    // Illegal bursts: bad WRAP length, bad size, reserved burst type
    r0 = rd_cnt;
    for (int k = 0; k < 3; k++) exp_q.push_back(beat_err(3'd3, k == 2));
    send_ar(3'd3, BASE + 32'h18, 8'd2, 3'd3, 2'b10, t);
    wait_done("wrap2_timeout");
    for (int k = 0; k < 2; k++) exp_q.push_back(beat_err(3'd4, k == 1));
    send_ar(3'd4, BASE + 32'h20, 8'd1, 3'd2, 2'b01, t);
    wait_done("size2_timeout");
    exp_q.push_back(beat_err(3'd6, 1'b1));
    send_ar(3'd6, BASE + 32'h20, 8'd0, 3'd3, 2'b11, t);
    wait_done("burst3_timeout");
    check("illegal_rd_count", 72'(rd_cnt - r0), 72'd0);

    // Window edges: crossing the top, and below the base
    r0 = rd_cnt;
    exp_q.push_back(beat_ok(3'd7, 8191, 1'b0));
    exp_q.push_back(beat_err(3'd7, 1'b1));
    send_ar(3'd7, BASE + 32'hFFF8, 8'd1, 3'd3, 2'b01, t);
    wait_done("edge_timeout");
    exp_q.push_back(beat_err(3'd0, 1'b1));
    send_ar(3'd0, BASE - 32'd8, 8'd0, 3'd3, 2'b01, t);
    wait_done("below_timeout");
    check("window_rd_count", 72'(rd_cnt - r0), 72'd1);

    // Backpressure on beat 1 of a 2-beat burst
    rready = 1'b0;
    r0 = rd_cnt;
    exp_q.push_back(beat_ok(3'd2, 8, 1'b0));
    exp_q.push_back(beat_ok(3'd2, 9, 1'b1));
    send_ar(3'd2, BASE + 32'h40, 8'd1, 3'd3, 2'b01, t);
    n = 0;
    while (!rvalid && n < 20) begin
      @(negedge clock);
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      check("stall_hold", obs, beat_ok(3'd2, 8, 1'b0));
      @(negedge clock);
    end
    check("stall_rd_count", 72'(rd_cnt - r0), 72'd1);
    @(posedge clock); #1;
    rready = 1'b1;
    wait_done("stall_timeout");
    check("stall_total_rd", 72'(rd_cnt - r0), 72'd2);

    // Reset while beat 2 of 4 is on the bus
    exp_q.push_back(beat_ok(3'd3, 16, 1'b0));
    send_ar(3'd3, BASE + 32'h80, 8'd3, 3'd3, 2'b01, t);
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    @(posedge clock); #1;
    rready = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("midreset_rvalid_before", 72'(rvalid), 72'd1);
    reset = 1'b0;
    #1;
    check("midreset_r_outputs", obs, 72'd0);
    check("midreset_ctrl", 72'({arready, mem_rd_en, mem_addr}), 72'd0);
    check("midreset_state", 72'(dbg_state), 72'd0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    rready = 1'b1;
    @(posedge clock); #1;
    b0 = beats_seen; r0 = rd_cnt;
    exp_q.push_back(beat_ok(3'd4, 32, 1'b1));
    send_ar(3'd4, BASE + 32'h100, 8'd0, 3'd3, 2'b01, t);
    wait_done("post_reset_timeout");
    repeat (6) @(posedge clock);
    #1;
    check("post_reset_beats", 72'(beats_seen - b0), 72'd1);
    check("post_reset_rd", 72'(rd_cnt - r0), 72'd1);

`ifdef EL2_IFU_AXI_RD_RESP_ARQ_EN
    begin : arq_test
      int acc0, acc1, acc2;
      for (int k = 0; k < 3; k++) exp_q.push_back(beat_ok(3'(k + 1), 64 + k, 1'b1));
      send_ar(3'd1, BASE + 32'h200, 8'd0, 3'd3, 2'b01, acc0);
      send_ar(3'd2, BASE + 32'h208, 8'd0, 3'd3, 2'b01, acc1);
      send_ar(3'd3, BASE + 32'h210, 8'd0, 3'd3, 2'b01, acc2);
      check("arq_second_accept", 72'(acc1 - acc0), 72'd1);
      check("arq_third_accept", 72'(acc2 - acc0), 72'd2);
      wait_done("arq_timeout");
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/el2_ifu_axi_rd_resp.md
EL2_IFU_AXI_RD_RESP -- requirements
Module: el2_ifu_axi_rd_resp

Interface
REQ-001 Parameter MEM_BASE, default 32'h0000_0000: byte base address of the served window.
REQ-002 Parameter MEM_AW, default 16: log2 of window size in bytes; the window is MEM_BASE .. MEM_BASE+2^MEM_AW-1.
REQ-003 clock  in  1  single clock; all logic rising-edge.
REQ-004 reset  in  1  asynchronous active-low reset.
REQ-005 io_ifu_axi_arvalid / io_ifu_axi_arready  in / out  1 / 1  AR handshake.
REQ-006 io_ifu_axi_arid  in  3  transaction ID.
REQ-007 io_ifu_axi_araddr  in  32  start byte address.
REQ-008 io_ifu_axi_arlen  in  8  beats minus one.
REQ-009 io_ifu_axi_arsize  in  3  beat size.
REQ-010 io_ifu_axi_arburst  in  2  burst type.
REQ-011 io_ifu_axi_rvalid / io_ifu_axi_rready  out / in  1 / 1  R handshake.
REQ-012 io_ifu_axi_rid  out  3  echoed ID.
REQ-013 io_ifu_axi_rdata  out  64  beat data.
REQ-014 io_ifu_axi_rresp  out  2  beat response.
REQ-015 io_ifu_axi_rlast  out  1  last beat.
REQ-016 io_mem_rd_en  out  1  backing-store read strobe.
REQ-017 io_mem_addr  out  MEM_AW-3  64-bit word index.
REQ-018 io_mem_rd_data  in  64  read data; valid the cycle after io_mem_rd_en and held until the next io_mem_rd_en.

Function
REQ-019 FSM states IDLE, RD, RSP; exactly one AXI burst is in service at a time.
REQ-020 io_ifu_axi_arready SHALL be 1 only in IDLE (without the queue of REQ-037).
REQ-021 AR handshake in IDLE latches id, addr, len, size and burst, clears the beat counter, and moves to RD.
REQ-022 RD, beat address in window: io_mem_rd_en=1 and io_mem_addr=beat_addr[MEM_AW-1:3] for exactly one cycle, then RSP.
REQ-023 RD, beat address outside window, or illegal burst (REQ-029): no memory read, then RSP with rresp=2'b10 (SLVERR) and rdata=0.
REQ-024 RSP: rvalid=1, rid=latched id, rdata=io_mem_rd_data, rresp=2'b00 (OKAY) or 2'b10 (SLVERR).
REQ-025 rlast=1 when beat counter==len.
REQ-026 rvalid, rdata, rresp, rlast and rid SHALL stay stable while rready=0.
REQ-027 R handshake with rlast=0: advance beat address and counter, go to RD. R handshake with rlast=1: go to IDLE.
REQ-028 Latency: AR handshake at cycle T gives first rvalid at T+2. With rready held 1, beats follow every 2 cycles.
REQ-029 Legal burst is arsize==3 and one of:
- arburst==2'b00 (FIXED)
- arburst==2'b01 (INCR)
- arburst==2'b10 (WRAP) with arlen in {1,3,7,15}
Any other combination returns len+1 SLVERR beats, rdata=0, rlast on the final one.
REQ-030 Beat address update:
- FIXED: unchanged.
- INCR: +8, 32-bit modulo.
- WRAP: +8 within an aligned (len+1)*8-byte boundary; the low bits wrap to the boundary start.
REQ-031 The window check SHALL be made per beat: an INCR burst crossing the window end returns OKAY for in-window beats and SLVERR for the rest.
REQ-032 Start address bits [2:0] SHALL be ignored; beats are word-aligned.
REQ-033 arlen=0 gives one beat with rlast=1.

Reset
REQ-034 Asserting reset at any time, including mid-burst, forces IDLE immediately. Burst state is discarded; no further beats are sent.
REQ-035 Reset values: arready=0, then 1 in the first cycle after deassertion; rvalid=0, rlast=0, rid=0, rresp=0, rdata=0, io_mem_rd_en=0, io_mem_addr=0.

Configuration
REQ-036 Macro EL2_IFU_AXI_RD_RESP_ARQ_EN controls the AR queue.
REQ-037 Defined: a 2-entry AR FIFO sits in front of the FSM.
- arready = FIFO not full, in any state.
- IDLE pops the head. A push and a pop in the same cycle are allowed when the FIFO is full.
- Bursts are served strictly in acceptance order.
- In IDLE with a non-empty FIFO, the next RD follows the final R handshake by 1 cycle.
- Reset empties the FIFO.
REQ-038 Not defined: no FIFO; REQ-020 applies.

Verification
REQ-039 INCR, araddr=MEM_BASE+0x10, arlen=3, id=5, rready=1 -> 4 OKAY beats, words 2,3,4,5, rid=5, rlast on beat 4, first rvalid at T+2.
REQ-040 WRAP, araddr=MEM_BASE+0x18, arlen=3 -> word order 3,0,1,2; WRAP with arlen=2 -> 3 SLVERR beats, io_mem_rd_en never asserted.
REQ-041 INCR starting at the last window word, arlen=1 -> beat 1 OKAY, beat 2 SLVERR, rlast=1 on beat 2.
REQ-042 rready held 0 for 5 cycles on beat 1 of a 2-beat burst -> R outputs constant throughout, single io_mem_rd_en per beat.
REQ-043 reset asserted during RSP of beat 2 of 4 -> rvalid=0 in the same cycle; after release, a new arlen=0 burst returns exactly 1 beat.
REQ-044 With EL2_IFU_AXI_RD_RESP_ARQ_EN, three back-to-back ARs (ids 1,2,3) with rready=1 -> the third is accepted only after the first starts service; R ids arrive in order 1,2,3.
